// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared ALU/result/immediate codes, opcodes and the Execute-stage control bundle
package ctrl_pkg;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR = 4'h3,
                         ALU_XOR = 4'h4, ALU_SLT = 4'h5, ALU_SLTU = 4'h6, ALU_SLL = 4'h7,
                         ALU_SRL = 4'h8, ALU_BGE = 4'h9, ALU_BGEU = 4'hA, ALU_SRA = 4'hB,
                         ALU_BNE = 4'hC, ALU_LUI = 4'hF;
  localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_MD = 2'b11;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT = 7'b0100000, F7_M = 7'b0000001;
  typedef struct packed {
    logic       reg_write;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       alu_src_a;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] result_src;
    logic [2:0] addr_ctrl;
    logic       muldiv;
    logic [2:0] muldiv_op;
    logic       illegal;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t CTRL_BUBBLE = '0;
  // funct3 to ALU op for register/immediate arithmetic; alt picks SUB/SRA
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000: alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational RV32I/RV32M decode of op/funct3/funct7 into an E control bundle
// Ports: op, funct3, funct7 in; ctrl (bundle incl. illegal flag), imm_src out
module control_decode
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output ctrl_bundle_t ctrl,
  output logic [2:0]   imm_src
);
  always_comb begin
    ctrl = CTRL_BUBBLE;
    imm_src = IMM_I;
    case (op)
      OPC_R:
        if (funct7 == F7_M) begin
          if (ENABLE_M) begin
            ctrl.reg_write = 1'b1;
            ctrl.result_src = RES_MD;
            ctrl.muldiv = 1'b1;
            ctrl.muldiv_op = funct3;
          end else ctrl.illegal = 1'b1;
        end else begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_control = alu_op(funct3, funct7 == F7_ALT);
        end
      OPC_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        // only the shift slot honours funct7; ADDI never becomes SUB
        ctrl.alu_control = alu_op(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.addr_ctrl = funct3;
      end
      OPC_STORE: begin
        imm_src = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.addr_ctrl = funct3;
      end
      OPC_BRANCH: begin
        imm_src = IMM_B;
        case (funct3)
          3'b000: ctrl.alu_control = ALU_SUB;
          3'b001: ctrl.alu_control = ALU_BNE;
          3'b100: ctrl.alu_control = ALU_SLT;
          3'b101: ctrl.alu_control = ALU_BGE;
          3'b110: ctrl.alu_control = ALU_SLTU;
          3'b111: ctrl.alu_control = ALU_BGEU;
          default: ctrl.illegal = 1'b1;
        endcase
        ctrl.branch = !ctrl.illegal;
      end
      OPC_JAL: begin
        imm_src = IMM_J;
        ctrl.reg_write = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.jalr = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OPC_LUI: begin
        imm_src = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_control = ALU_LUI;
      end
      OPC_AUIPC: begin
        imm_src = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_src_a = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_unit_m.sv
// control_unit_m: decode-stage control with registered E bundle and multi-cycle M-op sequencer
// Ports: clk, rst (sync, active high), instr_valid_i/op/funct3/funct7 decode inputs, stall_i/flush_i
// from the hazard unit; ImmSrcD combinational; *E registered Execute controls; stall_o holds PC and
// IF/ID; busy_o high while an M-op occupies E past its first cycle.
module control_unit_m
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 33,
  parameter bit ENABLE_M    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid_i,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic [2:0] ImmSrcD,
  output logic       RegWriteE,
  output logic [3:0] ALUControlE,
  output logic       ALUSrcE,
  output logic       ALUSrcAE,
  output logic       MemWriteE,
  output logic       branchE,
  output logic       jumpE,
  output logic       jalrE,
  output logic [1:0] ResultSrcE,
  output logic [2:0] AddressingControlE,
  output logic       MulDivE,
  output logic [2:0] MulDivOpE,
  output logic       IllegalE,
  output logic       stall_o,
  output logic       busy_o
);
  localparam int MAX_LAT = MUL_LATENCY > DIV_LATENCY ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW = $clog2(MAX_LAT) + 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt, lat;
  ctrl_bundle_t dec, e;
  logic load, long_op;
  control_decode #(.ENABLE_M(ENABLE_M)) u_dec (
    .op(op), .funct3(funct3), .funct7(funct7), .ctrl(dec), .imm_src(ImmSrcD)
  );
  assign lat = dec.muldiv_op[2] ? CW'(DIV_LATENCY) : CW'(MUL_LATENCY);
  assign load = state == IDLE && instr_valid_i && !flush_i && !stall_i;
  assign long_op = load && dec.muldiv && lat > CW'(1);
  assign busy_o = state == BUSY;
  assign stall_o = busy_o || long_op;
  // E holds during BUSY and for the one IDLE cycle after, so the M-op stays for exactly L cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      e <= CTRL_BUBBLE;
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) state <= IDLE;
    end else begin
      e <= load ? dec : CTRL_BUBBLE;
      if (long_op) begin
        state <= BUSY;
        cnt <= lat - CW'(1);
      end
    end
  end
  assign RegWriteE = e.reg_write;
  assign ALUControlE = e.alu_control;
  assign ALUSrcE = e.alu_src;
  assign ALUSrcAE = e.alu_src_a;
  assign MemWriteE = e.mem_write;
  assign branchE = e.branch;
  assign jumpE = e.jump;
  assign jalrE = e.jalr;
  assign ResultSrcE = e.result_src;
  assign AddressingControlE = e.addr_ctrl;
  assign MulDivE = e.muldiv;
  assign MulDivOpE = e.muldiv_op;
  assign IllegalE = e.illegal;
endmodule

// File: tb/tb_control_unit_m.sv
// tb_control_unit_m: scoreboard bench for control_unit_m with a hold-count reference model
module tb_control_unit_m;
  localparam int DL = 33, ML = 1;
  // funct3 -> ALU tables, entry for funct3=0 in the low nibble
  localparam logic [31:0] RTAB = {4'h2, 4'h3, 4'h8, 4'h4, 4'h6, 4'h5, 4'h7, 4'h0};
  localparam logic [31:0] BTAB = {4'hA, 4'h6, 4'h9, 4'h5, 4'h0, 4'h0, 4'hC, 4'h1};
  localparam logic [62:0] OPS = {7'h17, 7'h37, 7'h67, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h13, 7'h33};
  localparam logic [20:0] F7S = {7'h01, 7'h20, 7'h00};
  logic clk = 0, rst = 1, instr_valid_i = 0, stall_i = 0, flush_i = 0;
  logic [6:0] op = 0, funct7 = 0;
  logic [2:0] funct3 = 0;
  logic [2:0] ImmSrcD, AddressingControlE, MulDivOpE;
  logic [3:0] ALUControlE;
  logic [1:0] ResultSrcE;
  logic RegWriteE, ALUSrcE, ALUSrcAE, MemWriteE, branchE, jumpE, jalrE, MulDivE, IllegalE, stall_o, busy_o;
  control_unit_m dut (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .op(op), .funct3(funct3), .funct7(funct7),
    .stall_i(stall_i), .flush_i(flush_i), .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .MemWriteE(MemWriteE),
    .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE), .ResultSrcE(ResultSrcE),
    .AddressingControlE(AddressingControlE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .IllegalE(IllegalE), .stall_o(stall_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic rw; logic [3:0] alu; logic src, srca, mw, br, j, jr;
    logic [1:0] res; logic [2:0] addr; logic md; logic [2:0] mdop; logic ill;
  } ebun_t;
  typedef struct {bit chk; logic busy, stall; logic [2:0] imm;} cexp_t;
  typedef struct {int due; ebun_t e;} eexp_t;
  cexp_t qc[$];
  eexp_t qe[$];
  int checks = 0, failures = 0, cyc = 0, busy_left = 0;
  bit known = 0;
  ebun_t e_mod = '0, act;
  assign act = {RegWriteE, ALUControlE, ALUSrcE, ALUSrcAE, MemWriteE, branchE, jumpE, jalrE,
                ResultSrcE, AddressingControlE, MulDivE, MulDivOpE, IllegalE};
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ref_dec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                  output ebun_t e, output logic [2:0] imm);
    e = '0;
    imm = 3'd0;
    if (o == 7'h33 && f7 == 7'h01) begin e.rw = 1; e.res = 2'd3; e.md = 1; e.mdop = f3; end
    else if (o == 7'h33) begin
      e.rw = 1;
      e.alu = (f7 == 7'h20 && f3 == 0) ? 4'h1 : (f7 == 7'h20 && f3 == 5) ? 4'hB : RTAB[{f3, 2'b00} +: 4];
    end else if (o == 7'h13) begin
      e.rw = 1; e.src = 1;
      e.alu = (f7 == 7'h20 && f3 == 5) ? 4'hB : RTAB[{f3, 2'b00} +: 4];
    end else if (o == 7'h03) begin e.rw = 1; e.src = 1; e.res = 2'd1; e.addr = f3; end
    else if (o == 7'h23) begin e.mw = 1; e.src = 1; e.addr = f3; imm = 3'd1; end
    else if (o == 7'h63) begin
      imm = 3'd2;
      if (f3 == 2 || f3 == 3) e.ill = 1;
      else begin e.br = 1; e.alu = BTAB[{f3, 2'b00} +: 4]; end
    end else if (o == 7'h6F) begin e.rw = 1; e.j = 1; e.res = 2'd2; imm = 3'd3; end
    else if (o == 7'h67) begin e.rw = 1; e.j = 1; e.jr = 1; e.src = 1; e.res = 2'd2; end
    else if (o == 7'h37) begin e.rw = 1; e.alu = 4'hF; e.src = 1; imm = 3'd4; end
    else if (o == 7'h17) begin e.rw = 1; e.srca = 1; e.src = 1; imm = 3'd4; end
    else e.ill = 1;
  endfunction

  // one cycle of stimulus; expectations pushed for the scoreboard, ld reports the model loaded E
  task automatic step(input bit r, v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input bit st, fl, output bit ld);
    ebun_t d;
    logic [2:0] imm;
    int lat;
    bit busy;
    @(posedge clk);
    #1;
    rst = r; instr_valid_i = v; op = o; funct3 = f3; funct7 = f7; stall_i = st; flush_i = fl;
    ref_dec(o, f3, f7, d, imm);
    lat = d.md ? (f3[2] ? DL : ML) : 1;
    busy = busy_left > 0;
    ld = !busy && v && !st && !fl && !r;
    qc.push_back('{known, busy, busy || (v && !st && !fl && lat > 1), imm});
    if (r) begin e_mod = '0; busy_left = 0; known = 1; end
    else if (busy) busy_left--;
    else if (ld) begin e_mod = d; busy_left = lat - 1; end
    else e_mod = '0;
    qe.push_back('{cyc + 1, e_mod});
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    bit ld;
    int n = 0;
    do begin step(0, 1, o, f3, f7, 0, 0, ld); n++; end while (!ld && n < 100);
  endtask

  always @(negedge clk) begin
    cexp_t c;
    eexp_t x;
    if (qc.size() > 0) begin
      c = qc.pop_front();
      if (c.chk) begin
        checks++;
        if (busy_o !== c.busy || stall_o !== c.stall || ImmSrcD !== c.imm) begin
          failures++;
          $display("FAIL comb cyc=%0d got busy=%b stall=%b imm=%h want busy=%b stall=%b imm=%h",
                   cyc, busy_o, stall_o, ImmSrcD, c.busy, c.stall, c.imm);
        end
      end
    end
    while (qe.size() > 0 && qe[0].due <= cyc) begin
      x = qe.pop_front();
      checks++;
      if (act !== x.e) begin
        failures++;
        $display("FAIL ebundle cyc=%0d got %h want %h", cyc, act, x.e);
      end
    end
  end

  initial begin
    bit ld;
    logic [6:0] o, f7;
    int k;
    step(1, 0, 0, 0, 0, 0, 0, ld);
    step(1, 0, 0, 0, 0, 0, 0, ld);
    step(0, 1, 7'h33, 3'd0, 7'h00, 0, 0, ld);
    step(0, 1, 7'h33, 3'd0, 7'h20, 0, 0, ld);
    step(0, 1, 7'h63, 3'd0, 7'h00, 0, 0, ld);
    step(0, 1, 7'h63, 3'd1, 7'h00, 0, 0, ld);
    step(0, 1, 7'h63, 3'd5, 7'h00, 0, 0, ld);
    step(0, 1, 7'h63, 3'd2, 7'h00, 0, 0, ld);
    issue(7'h33, 3'd4, 7'h01);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 0, i == 4, ld);
    step(0, 1, 7'h33, 3'd0, 7'h00, 0, 1, ld);
    issue(7'h33, 3'd4, 7'h01);
    issue(7'h33, 3'd5, 7'h01);
    issue(7'h33, 3'd0, 7'h01);
    issue(7'h33, 3'd6, 7'h00);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 0, 0, ld);
    issue(7'h33, 3'd7, 7'h01);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, ld);
    step(1, 0, 0, 0, 0, 0, 0, ld);
    step(1, 0, 0, 0, 0, 0, 0, ld);
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 9);
      o = k == 9 ? 7'($urandom) : OPS[k*7 +: 7];
      k = $urandom_range(0, 3);
      f7 = k == 3 ? 7'($urandom) : F7S[k*7 +: 7];
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, o, 3'($urandom), f7,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, ld);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, ld);
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_unit_m.md
Name: control_unit_m

Overview:
- Successor to the pipelined decode-stage control unit. Decodes RV32I plus the RV32M multiply/divide group and registers the control bundle into the Execute stage (D→E pipeline register for control only).
- Adds a sequencer for variable-latency M operations: it stalls fetch/decode and holds the E bundle while the multi-cycle unit runs.
- Flags illegal opcodes.
- Sits in id_stage between the instruction register and the ID/EX datapath register; the hazard unit supplies stall/flush.

Parameters:
- MUL_LATENCY, 1, cycles a MUL* occupies E (1 = no stall).
- DIV_LATENCY, 33, cycles a DIV*/REM* occupies E.
- ENABLE_M, 1, 0 = opcode 0110011 with funct7=0000001 decodes as illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid_i  in  1  decode-stage instruction valid
- op  in  7  opcode
- funct3  in  3  funct3
- funct7  in  7  funct7
- stall_i  in  1  hazard-unit load-use stall (inject bubble into E)
- flush_i  in  1  branch/jump redirect flush of E
- ImmSrcD  out  3  combinational: 000 I, 001 S, 010 B, 011 J, 100 U
- RegWriteE  out  1  registered register-file write enable
- ALUControlE  out  4  registered ALU op
- ALUSrcE  out  1  registered; 1 = immediate as operand B
- ALUSrcAE  out  1  registered; 1 = PC as operand A (AUIPC)
- MemWriteE  out  1  registered memory write enable
- branchE, jumpE, jalrE  out  1 each  registered control-flow flags
- ResultSrcE  out  2  registered: 00 ALU, 01 mem, 10 PC+4, 11 muldiv
- AddressingControlE  out  3  registered load/store funct3
- MulDivE  out  1  registered; M-op valid in E
- MulDivOpE  out  3  registered M funct3
- IllegalE  out  1  registered illegal-instruction flag
- stall_o  out  1  combinational; hold PC and IF/ID
- busy_o  out  1  sequencer in BUSY

Behaviour:
- ALU encodings:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8.
  - BGE 9, BGEU A, SRA B, BNE C, LUI F.
- Decode rules:
  - R-type: funct7=0100000 selects SUB/SRA; otherwise ADD/SRL.
  - I-ALU: SRAI only when funct7=0100000.
  - Branch: branch=1 for funct3 000/001/100/101/110/111 with ALU SUB/BNE/SLT/BGE/SLTU/BGEU. funct3 010/011 → illegal.
  - Load/store: AddressingControl=funct3, ALU ADD, ALUSrc=1.
  - JAL: jump=1, ResultSrc=10.
  - JALR: jump=1, jalr=1, ALUSrc=1.
  - LUI: ALU LUI, ALUSrc=1.
  - AUIPC (0010111): ImmSrc U, ALUSrcA=1, ALUSrc=1, ADD, RegWrite=1.
  - M-op: RegWrite=1, ResultSrc=11, MulDiv=1, MulDivOp=funct3.
  - Any other opcode → Illegal=1 with all write enables 0.
- Bubble: all E outputs 0 (ALU ADD, ResultSrc 00).
- Reset: E bundle = bubble, FSM IDLE, counter 0, stall_o=0, busy_o=0.
- E-register update priority, highest first:
  1. rst
  2. BUSY (hold E bundle)
  3. flush_i → bubble
  4. stall_i → bubble
  5. !instr_valid_i → bubble
  6. otherwise load decoded bundle
- Latency: decode to E outputs is 1 cycle.
- FSM states IDLE and BUSY; counter width $clog2(max latency)+1.
  - IDLE→BUSY when an M-op with L>1 is loaded into E; counter := L-1. L is DIV_LATENCY for funct3[2]=1, otherwise MUL_LATENCY.
  - BUSY: counter decrements each cycle; counter==1 → IDLE on the next edge.
  - The M-op therefore holds E for exactly L cycles.
- stall_o = busy_o | (IDLE & M-op with L>1 being loaded this cycle). stall_i does not drive stall_o.
- flush_i or stall_i during BUSY is ignored: the in-flight M-op is older and must complete. The hazard unit re-asserts after BUSY ends.
- rst during BUSY aborts to IDLE with a bubble in E.
- Back-to-back M-ops: the second sits in D under stall_o and is loaded on the cycle BUSY exits. No idle gap.
- With MUL_LATENCY=1, MUL never enters BUSY.

Decomposition:
- Package ctrl_pkg holds:
  - ALU_* localparams.
  - ResultSrc and ImmSrc codes.
  - OPC_* opcode constants.
  - Packed struct ctrl_bundle_t for the E bundle, with a CTRL_BUBBLE constant.
- Sub-module control_decode: purely combinational, maps op/funct3/funct7 → ctrl_bundle_t, ImmSrc and illegal.
- Top: E register, FSM, counter.

Test Plan:
- rst=1 two cycles, mid-sequence → all E outputs 0, busy_o=0, stall_o=0.
- add x1,x2,x3 then sub (funct7 0100000) → ALUControlE 0 then 1, RegWriteE=1, exactly 1-cycle latency.
- beq/bne/bge, and funct3=010 → branchE=1 with ALUControlE 1/C/9; for 010 branchE=0, IllegalE=1.
- div (funct3 100), DIV_LATENCY=33 → stall_o=1 for 33 consecutive cycles, busy_o=1 for 32, E bundle stable, IDLE after.
- flush_i pulsed on BUSY cycle 5 → ignored, MulDivE stays 1; flush_i in IDLE → next E bundle is a bubble.
- Two consecutive divs, then mul with MUL_LATENCY=1 → second div loaded on the exit cycle; mul causes no stall; ResultSrcE=11 each.
